cos_sweep_ctrl: RTL and testbench

- Initiator for the team's fixed-point Taylor cosine core. Drives the core's start/angle handshake and collects its result.
- Generates a programmed angle sweep: base, base+step, ..., count points.
- Issues each angle to the core, waits for completion, captures the result, and returns the core to idle.
- Streams (angle, cos) pairs out over a valid/ready interface to downstream logging/DMA.

---
 rtl/cos_pkg.sv | 23 ++
 rtl/cos_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_cos_sweep_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cos_pkg.sv
// -----------------------------------------------------------------------------
// cos_pkg
// Shared definitions for the Taylor cosine core and its sweep controller.
//   FXP_SHIFT / FXP_ONE : Q(W-10).10 fixed-point format, 1.0 = 1024
//   COS_W               : default datapath width
//   sweep_state_t       : sweep controller FSM states
// -----------------------------------------------------------------------------
package cos_pkg;

    localparam int FXP_SHIFT = 10;
    localparam int FXP_ONE   = 1024;
    localparam int COS_W     = 24;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_CLR = 3'd2,
        WAIT_RDY = 3'd3,
        OUTPUT   = 3'd4,
        GAP      = 3'd5
    } sweep_state_t;

endpackage

// File: rtl/cos_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// cos_sweep_ctrl
// Initiator for the fixed-point Taylor cosine core. It walks an angle sweep
// (base, base+step, ... for count points), hands each angle to the core, waits
// for the result and streams (angle, cos) pairs downstream.
//
// Ports
//   clock, reset            : clock, asynchronous active-high reset
//   go, cfg_base/step/count : start a sweep (ignored while busy)
//   busy, done              : sweep in progress / one-cycle end-of-sweep pulse
//   core_start, core_angle  : request to the cosine core
//   core_ready, core_cos    : core result flag (level, stale-high) and result
//   res_valid/ready         : output stream handshake
//   res_angle/cos/last      : output sample, last marks the final point
//   err_timeout             : sticky core-timeout flag (COS_SWEEP_TIMEOUT_EN)
//   dbg_state               : current FSM state
//
// Handshake: a sample transfers on a clock edge where res_valid && res_ready;
// res_* are held stable while res_valid=1 and res_ready=0.
//
// Build option: define COS_SWEEP_TIMEOUT_EN to add the core-response timeout
// (parameter TO_CYC and output err_timeout). Without it the block waits on the
// core indefinitely.
// -----------------------------------------------------------------------------
module cos_sweep_ctrl
    import cos_pkg::*;
#(
    parameter int W     = COS_W,
    parameter int CNT_W = 16
`ifdef COS_SWEEP_TIMEOUT_EN
    ,
    parameter int TO_CYC = 64
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [W-1:0]     cfg_base,
    input  logic [W-1:0]     cfg_step,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             busy,
    output logic             done,
    output logic             core_start,
    output logic [W-1:0]     core_angle,
    input  logic             core_ready,
    input  logic [W-1:0]     core_cos,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_angle,
    output logic [W-1:0]     res_cos,
    output logic             res_last,
`ifdef COS_SWEEP_TIMEOUT_EN
    output logic             err_timeout,
`endif
    output sweep_state_t     dbg_state
);

    sweep_state_t     state_q, state_d;
    logic [W-1:0]     angle_q, angle_d;
    logic [W-1:0]     step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;       // points still to be delivered
    logic             gap_q, gap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             core_start_q, core_start_d;
    logic [W-1:0]     core_angle_q, core_angle_d;
    logic             res_valid_q, res_valid_d;
    logic [W-1:0]     res_angle_q, res_angle_d;
    logic [W-1:0]     res_cos_q, res_cos_d;
    logic             res_last_q, res_last_d;
`ifdef COS_SWEEP_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        angle_d      = angle_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        core_start_d = core_start_q;
        core_angle_d = core_angle_q;
        res_valid_d  = res_valid_q;
        res_angle_d  = res_angle_q;
        res_cos_d    = res_cos_q;
        res_last_d   = res_last_q;
`ifdef COS_SWEEP_TIMEOUT_EN
        to_cnt_d     = '0;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (go) begin
                    angle_d = cfg_base;
                    step_d  = cfg_step;
                    cnt_d   = cfg_count;
`ifdef COS_SWEEP_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    // An empty sweep only produces the done pulse.
                    if (cfg_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                core_angle_d = angle_q;
                core_start_d = 1'b1;
                state_d      = WAIT_CLR;
            end
            WAIT_CLR: begin
                // The ready flag is still high from the previous op; its
                // falling edge is the core accepting this one.
                if (!core_ready) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (core_ready) begin
                    res_cos_d    = core_cos;
                    res_angle_d  = core_angle_q;
                    res_valid_d  = 1'b1;
                    res_last_d   = (cnt_q == CNT_W'(1));
                    core_start_d = 1'b0;
                    state_d      = OUTPUT;
                end
            end
            OUTPUT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    angle_d     = angle_q + step_q;
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        gap_d   = 1'b0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // Two cycles of start low so the core is back in idle.
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = ISSUE;
                end else begin
                    gap_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef COS_SWEEP_TIMEOUT_EN
        // Counts cycles spent waiting without the expected core_ready level.
        if ((state_q == WAIT_CLR && core_ready) || (state_q == WAIT_RDY && !core_ready)) begin
            if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
                core_start_d = 1'b0;
                err_d        = 1'b1;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            angle_q      <= '0;
            step_q       <= '0;
            cnt_q        <= '0;
            gap_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            core_start_q <= 1'b0;
            core_angle_q <= '0;
            res_valid_q  <= 1'b0;
            res_angle_q  <= '0;
            res_cos_q    <= '0;
            res_last_q   <= 1'b0;
`ifdef COS_SWEEP_TIMEOUT_EN
            to_cnt_q     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            angle_q      <= angle_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            core_start_q <= core_start_d;
            core_angle_q <= core_angle_d;
            res_valid_q  <= res_valid_d;
            res_angle_q  <= res_angle_d;
            res_cos_q    <= res_cos_d;
            res_last_q   <= res_last_d;
`ifdef COS_SWEEP_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign core_start = core_start_q;
    assign core_angle = core_angle_q;
    assign res_valid  = res_valid_q;
    assign res_angle  = res_angle_q;
    assign res_cos    = res_cos_q;
    assign res_last   = res_last_q;
    assign dbg_state  = state_q;
`ifdef COS_SWEEP_TIMEOUT_EN
    assign err_timeout = err_q;
`endif

endmodule

// File: tb/tb_cos_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cos_sweep_ctrl
// Directed bench for cos_sweep_ctrl with a behavioural cosine core behind the
// core_* ports: programmable latency, stale-high ready flag, a Taylor-series
// mode, an "angle+5" marker mode and a never-ready mode.
// -----------------------------------------------------------------------------
module tb_cos_sweep_ctrl;
    import cos_pkg::*;

    localparam int W     = 24;
    localparam int CNT_W = 16;

    logic             clock;
    logic             reset;
    logic             go;
    logic [W-1:0]     cfg_base;
    logic [W-1:0]     cfg_step;
    logic [CNT_W-1:0] cfg_count;
    logic             busy;
    logic             done;
    logic             core_start;
    logic [W-1:0]     core_angle;
    logic             core_ready;
    logic [W-1:0]     core_cos;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_angle;
    logic [W-1:0]     res_cos;
    logic             res_last;
    sweep_state_t     dbg_state;
`ifdef COS_SWEEP_TIMEOUT_EN
    logic             err_timeout;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];

    cos_sweep_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .go         (go),
        .cfg_base   (cfg_base),
        .cfg_step   (cfg_step),
        .cfg_count  (cfg_count),
        .busy       (busy),
        .done       (done),
        .core_start (core_start),
        .core_angle (core_angle),
        .core_ready (core_ready),
        .core_cos   (core_cos),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_angle  (res_angle),
        .res_cos    (res_cos),
        .res_last   (res_last),
`ifdef COS_SWEEP_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural cosine core ----------------
    int           mdl_lat  = 3;
    bit           mdl_mode = 1'b0;   // 0: Taylor cosine, 1: angle + 5
    bit           mdl_hang = 1'b0;   // never raise ready
    logic [1:0]   m_phase;
    int           m_cnt;
    logic [W-1:0] m_angle;

    function automatic logic [W-1:0] taylor_cos(input logic [W-1:0] a);
        longint x, x2, x4;
        x  = longint'($signed(a));
        x2 = (x * x) >>> FXP_SHIFT;
        x4 = (x2 * x2) >>> FXP_SHIFT;
        return W'(longint'(FXP_ONE) - x2 / 2 + x4 / 24);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            core_ready <= 1'b1;          // stale-high out of reset
            core_cos   <= '0;
            m_phase    <= 2'd0;
            m_cnt      <= 0;
            m_angle    <= '0;
        end else begin
            case (m_phase)
                2'd0: if (core_start) begin
                    core_ready <= 1'b0;
                    m_angle    <= core_angle;
                    m_cnt      <= mdl_lat;
                    m_phase    <= 2'd1;
                end
                2'd1: begin
                    if (!core_start) begin
                        m_phase <= 2'd0;
                    end else if (!mdl_hang && m_cnt == 0) begin
                        core_ready <= 1'b1;
                        core_cos   <= mdl_mode ? m_angle + W'(5) : taylor_cos(m_angle);
                        m_phase    <= 2'd2;
                    end else if (m_cnt > 0) begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: if (!core_start) m_phase <= 2'd0;
            endcase
        end
    end

    // ---------------- protocol monitor ----------------
    int start_rises = 0;
    int low_run     = 1000;
    int min_low     = 1000;
    bit valid_seen  = 1'b0;
    bit prev_start  = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            prev_start = 1'b0;
        end else begin
            if (core_start && !prev_start) begin
                start_rises++;
                if (low_run < min_low) min_low = low_run;
            end
            if (core_start) low_run = 0;
            else low_run++;
            if (res_valid) valid_seen = 1'b1;
            prev_start = core_start;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_go(input logic [W-1:0] b, input logic [W-1:0] s, input logic [CNT_W-1:0] c);
        cfg_base  = b;
        cfg_step  = s;
        cfg_count = c;
        go        = 1'b1;
        tick();
        go        = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        go        = 1'b0;
        cfg_base  = '0;
        cfg_step  = '0;
        cfg_count = '0;
        res_ready = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({busy, done, core_start, res_valid, res_last} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00000", {busy, done, core_start, res_valid, res_last});
        end
        vectors++;
        if ({res_angle, res_cos, core_angle} !== {3 * W{1'b0}}) begin
            miscompares++;
            $display("FAIL reset_data got %h/%h/%h want 0", res_angle, res_cos, core_angle);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (dbg_state !== IDLE || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle got state %0d busy %b want 0/0", dbg_state, busy);
        end
    endtask

    task automatic test_single_real();
        bit ok;
        mdl_mode = 1'b0;
        pulse_go(24'h000000, 24'h000000, 16'd1);
        wait_valid(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_valid timeout got 0 want 1");
        end
        vectors++;
        if ({res_angle, res_cos, res_last} !== {24'h000000, 24'h000400, 1'b1}) begin
            miscompares++;
            $display("FAIL single_sample got %h/%h/%b want 000000/000400/1", res_angle, res_cos, res_last);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++;
        if ({done, busy, res_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL single_done got done/busy/valid %b want 100", {done, busy, res_valid});
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_count_zero();
        start_rises = 0;
        valid_seen  = 1'b0;
        pulse_go(24'h000123, 24'h000010, 16'd0);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_done got %b want 1", done);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done_pulse got %b want 0", done);
        end
        repeat (5) tick();
        vectors++;
        if (start_rises !== 0 || valid_seen !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_quiet got starts %0d valid %b busy %b want 0/0/0", start_rises, valid_seen, busy);
        end
    endtask

    // Four points from 0x100 step 0x100; optional 10-cycle stall on point stall_pt.
    task automatic test_sweep(input int stall_pt);
        bit           ok;
        logic [W-1:0] ea;
        mdl_mode    = 1'b1;
        low_run     = 1000;
        min_low     = 1000;
        start_rises = 0;
        for (int p = 1; p <= 4; p++) exp_q.push_back(W'(p * 256));
        pulse_go(24'h000100, 24'h000100, 16'd4);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_busy got %b want 1", busy);
        end
        for (int p = 1; p <= 4; p++) begin
            wait_valid(ok);
            ea = exp_q.pop_front();
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL sweep_valid point %0d timeout", p);
            end
            vectors++;
            if ({res_angle, res_cos, res_last, core_start} !== {ea, ea + W'(5), (p == 4), 1'b0}) begin
                miscompares++;
                $display("FAIL sweep_sample point %0d got %h/%h/%b start %b want %h/%h/%b start 0",
                         p, res_angle, res_cos, res_last, core_start, ea, ea + W'(5), (p == 4));
            end
            if (p == stall_pt) begin
                for (int k = 0; k < 10; k++) begin
                    tick();
                    vectors++;
                    if ({res_valid, res_angle, res_cos, res_last, core_start} !==
                        {1'b1, ea, ea + W'(5), 1'b0, 1'b0}) begin
                        miscompares++;
                        $display("FAIL stall_hold cycle %0d got v%b %h/%h/%b start %b want v1 %h/%h/0 start 0",
                                 k, res_valid, res_angle, res_cos, res_last, core_start, ea, ea + W'(5));
                    end
                end
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            vectors++;
            if ({done, busy} !== {(p == 4), (p != 4)}) begin
                miscompares++;
                $display("FAIL sweep_done point %0d got done/busy %b%b want %b%b",
                         p, done, busy, (p == 4), (p != 4));
            end
        end
        vectors++;
        if (min_low < 2 || start_rises != 4) begin
            miscompares++;
            $display("FAIL sweep_gap got min low %0d starts %0d want >=2 and 4", min_low, start_rises);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        mdl_mode = 1'b1;
        exp_q.push_back(24'hFFFF00);
        exp_q.push_back(24'h000100);
        pulse_go(24'hFFFF00, 24'h000200, 16'd2);
        tick();
        pulse_go(24'h000123, 24'h000001, 16'd5);   // busy: must be ignored
        for (int p = 1; p <= 2; p++) begin
            logic [W-1:0] ea;
            wait_valid(ok);
            ea = exp_q.pop_front();
            vectors++;
            if (!ok || {res_angle, res_cos, res_last} !== {ea, ea + W'(5), (p == 2)}) begin
                miscompares++;
                $display("FAIL wrap_sample point %0d got ok %b %h/%h/%b want %h/%h/%b",
                         p, ok, res_angle, res_cos, res_last, ea, ea + W'(5), (p == 2));
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_done got %b want 1", done);
        end
        repeat (3) tick();
        vectors++;
        if (busy !== 1'b0 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL wrap_ignored_go got busy %b state %0d want 0/0", busy, dbg_state);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        mdl_mode = 1'b1;
        mdl_lat  = 20;
        pulse_go(24'h000040, 24'h000000, 16'd1);
        for (int i = 0; i < 50; i++) begin
            if (dbg_state == WAIT_RDY) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        vectors++;
        if (!found || core_start !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_reach got found %b start %b want 1/1", found, core_start);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({core_start, busy, res_valid} !== 3'b000 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL rstmid_async got start/busy/valid %b state %0d want 000/0",
                     {core_start, busy, res_valid}, dbg_state);
        end
        tick();
        reset   = 1'b0;
        mdl_lat = 3;
        tick();
    endtask

`ifdef COS_SWEEP_TIMEOUT_EN
    task automatic test_timeout();
        int cycles = 0;
        bit seen   = 1'b0;
        mdl_hang   = 1'b1;
        valid_seen = 1'b0;
        pulse_go(24'h000000, 24'h000000, 16'd1);
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
        vectors++;
        if (!seen || cycles < 64 || cycles > 72) begin
            miscompares++;
            $display("FAIL timeout_done got seen %b after %0d cycles want 1 within 64..72", seen, cycles);
        end
        vectors++;
        if ({err_timeout, busy, core_start, valid_seen} !== 4'b1000) begin
            miscompares++;
            $display("FAIL timeout_state got err/busy/start/valid %b want 1000",
                     {err_timeout, busy, core_start, valid_seen});
        end
        mdl_hang = 1'b0;
        repeat (3) tick();
        vectors++;
        if (err_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky got %b want 1", err_timeout);
        end
        pulse_go(24'h000000, 24'h000000, 16'd0);
        vectors++;
        if (err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear got %b want 0", err_timeout);
        end
        tick();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_real();
        test_count_zero();
        test_sweep(0);
        test_sweep(2);
        test_wrap();
        test_reset_mid();
`ifdef COS_SWEEP_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
